// File: rtl/alu.sv
// ============================================================================
//  Module   : alu
//  Brief    : 32-bit single-cycle registered ALU with Z/N/V/C flags.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALUControl,
    output logic [31:0] Result,
    output logic        Ze,
    output logic        N,
    output logic        V,
    output logic        C
);

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_AND  = 3'b010;
    localparam logic [2:0] c_OP_OR   = 3'b011;
    localparam logic [2:0] c_OP_XOR  = 3'b100;
    localparam logic [2:0] c_OP_SLT  = 3'b101;
    localparam logic [2:0] c_OP_SLTU = 3'b110;

    logic [32:0] w_sum;
    logic [32:0] w_diff;
    logic        w_v_add;
    logic        w_v_sub;
    logic        w_slt;
    logic        w_sltu;
    logic [31:0] w_result;
    logic        w_v;
    logic        w_c;

    logic [31:0] r_result;
    logic        r_ze;
    logic        r_n;
    logic        r_v;
    logic        r_c;

    assign w_sum   = {1'b0, A} + {1'b0, B};
    assign w_diff  = {1'b0, A} + {1'b0, ~B} + 33'd1;
    assign w_v_add = (A[31] == B[31]) & (w_sum[31]  != A[31]);
    assign w_v_sub = (A[31] != B[31]) & (w_diff[31] != A[31]);
    // Signed compare uses the overflow-corrected sign so it survives wrap.
    assign w_slt   = w_diff[31] ^ w_v_sub;
    assign w_sltu  = ~w_diff[32];

    always_comb begin
        w_result = 32'h0;
        w_v      = 1'b0;
        w_c      = 1'b0;
        case (ALUControl)
            c_OP_ADD: begin
                w_result = w_sum[31:0];
                w_v      = w_v_add;
                w_c      = w_sum[32];
            end
            c_OP_SUB: begin
                w_result = w_diff[31:0];
                w_v      = w_v_sub;
                w_c      = w_diff[32];
            end
            c_OP_AND:  w_result = A & B;
            c_OP_OR:   w_result = A | B;
            c_OP_XOR:  w_result = A ^ B;
            c_OP_SLT:  w_result = {31'h0, w_slt};
            c_OP_SLTU: w_result = {31'h0, w_sltu};
            default:   w_result = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= 32'h0;
            r_ze     <= 1'b1;
            r_n      <= 1'b0;
            r_v      <= 1'b0;
            r_c      <= 1'b0;
        end else begin
            r_result <= w_result;
            r_ze     <= (w_result == 32'h0);
            r_n      <= w_result[31];
            r_v      <= w_v;
            r_c      <= w_c;
        end
    end

    assign Result = r_result;
    assign Ze     = r_ze;
    assign N      = r_n;
    assign V      = r_v;
    assign C      = r_c;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ============================================================================
//  Module   : tb_alu
//  Brief    : Self-checking bench for alu: directed vectors plus a reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUControl;
    logic [31:0] Result;
    logic        Ze;
    logic        N;
    logic        V;
    logic        C;

    int checks = 0;
    int errors = 0;

    logic [35:0] m_exp;
    logic        m_valid = 1'b0;

    alu dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .Result     (Result),
        .Ze         (Ze),
        .N          (N),
        .V          (V),
        .C          (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer arithmetic, flags derived from range checks.
    function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, s;
        longint unsigned ua, ub, u;
        logic [31:0] r;
        logic v, c;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = {32'h0, a};           ub = {32'h0, b};
        r = 32'h0; v = 1'b0; c = 1'b0;
        case (op)
            3'd0: begin
                s = sa + sb; u = ua + ub;
                r = a + b;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                c = (u >= 64'd4294967296);
            end
            3'd1: begin
                s = sa - sb;
                r = a - b;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                c = (ua >= ub);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (sa < sb) ? 32'h1 : 32'h0;
            3'd6: r = (ua < ub) ? 32'h1 : 32'h0;
            default: r = 32'h0;
        endcase
        return {r, (r == 32'h0), r[31], v, c};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m_exp = {32'h0, 4'b1000};
        else     m_exp = model(ALUControl, A, B);
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if ({Result, Ze, N, V, C} !== m_exp) begin
                errors++;
                $display("FAIL model t=%0t: got R=%h ZNVC=%b required R=%h ZNVC=%b",
                         $time, Result, {Ze, N, V, C}, m_exp[35:4], m_exp[3:0]);
            end
        end
    end

    task automatic check_now(input string name, input logic [35:0] exp);
        checks++;
        if ({Result, Ze, N, V, C} !== exp) begin
            errors++;
            $display("FAIL %s: got R=%h ZNVC=%b required R=%h ZNVC=%b",
                     name, Result, {Ze, N, V, C}, exp[35:4], exp[3:0]);
        end
    endtask

    task automatic step(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [35:0] exp);
        @(negedge clk);
        ALUControl = op; A = a; B = b;
        @(posedge clk);
        #1;
        check_now(name, exp);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; A = 32'h0; B = 32'h0; ALUControl = 3'd0;
        #1 rst = 1'b1;
        #2 check_now("reset_async", {32'h0, 4'b1000});
        repeat (2) @(posedge clk);
        #1 check_now("reset_hold", {32'h0, 4'b1000});
        @(negedge clk) rst = 1'b0;

        //      name          op    A             B             {Result, Ze N V C}
        step("add_5_3",     3'd0, 32'h5,        32'h3,        {32'h8,        4'b0000});
        step("sub_5_3",     3'd1, 32'h5,        32'h3,        {32'h2,        4'b0001});
        step("and_zero",    3'd2, 32'hF0F0F0F0, 32'h0F0F0F0F, {32'h0,        4'b1000});
        step("or_ones",     3'd3, 32'hF0F0F0F0, 32'h0F0F0F0F, {32'hFFFFFFFF, 4'b0100});
        step("slt_5_10",    3'd5, 32'h5,        32'hA,        {32'h1,        4'b0000});
        step("slt_neg",     3'd5, 32'h80000000, 32'h1,        {32'h1,        4'b0000});
        step("sltu_big",    3'd6, 32'h80000000, 32'h1,        {32'h0,        4'b1000});
        step("sltu_small",  3'd6, 32'h1,        32'h80000000, {32'h1,        4'b0000});
        step("slt_ovf",     3'd5, 32'h7FFFFFFF, 32'h80000000, {32'h0,        4'b1000});
        step("add_ovf",     3'd0, 32'h7FFFFFFF, 32'h1,        {32'h80000000, 4'b0110});
        step("add_carry",   3'd0, 32'hFFFFFFFF, 32'h1,        {32'h0,        4'b1001});
        step("sub_borrow",  3'd1, 32'h3,        32'h5,        {32'hFFFFFFFE, 4'b0100});
        step("sub_ovf",     3'd1, 32'h80000000, 32'h1,        {32'h7FFFFFFF, 4'b0011});
        step("sub_equal",   3'd1, 32'h5,        32'h5,        {32'h0,        4'b1001});
        step("xor",         3'd4, 32'hFF00FF00, 32'h0FF00FF0, {32'hF0F0F0F0, 4'b0100});
        step("op7_zero",    3'd7, 32'h1234,     32'h5678,     {32'h0,        4'b1000});

        step("rst_pre",     3'd0, 32'd10,       32'd20,       {32'd30,       4'b0000});
        @(negedge clk);
        A = 32'd100; B = 32'd1; ALUControl = 3'd0;
        #2 rst = 1'b1;
        #1 check_now("rst_midcycle", {32'h0, 4'b1000});
        @(posedge clk);
        #1 check_now("rst_edge_hold", {32'h0, 4'b1000});
        @(negedge clk);
        rst = 1'b0; A = 32'h2; B = 32'h2; ALUControl = 3'd1;
        @(posedge clk);
        #1 check_now("rst_release", {32'h0, 4'b1001});
        step("post_rst_add", 3'd0, 32'h1, 32'h1, {32'h2, 4'b0000});

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
